// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Shares one external combinational ALU between two requesters. Port 0 is
//   typically the integer pipe and port 1 a multi-cycle/coprocessor unit. Each
//   cycle at most one eligible requester is granted. The granted operands drive
//   the ALU, and the ALU result is registered into that requester's response
//   slot. Each slot has valid/ready back-pressure.
//
// Configuration:
//   ALU_ARB_FIXED_PRIO_EN  defined   -> fixed priority; port 0 always wins ties.
//                          undefined -> round-robin tie-break (default build).
//
// Ports:
//   clk_i                 clock; all state on the rising edge
//   rst_ni                asynchronous active-low reset
//   reqN_valid_i          requester N presents an operation (N = 0, 1)
//   reqN_ready_o          issue accepted this cycle (grant N)
//   reqN_a_i / reqN_b_i   operands
//   reqN_func_i           {func7[5], func3}
//   reqN_aluop_i          ALU op select
//   rspN_valid_o          result held for requester N
//   rspN_ready_i          requester N consumes the result
//   rspN_result_o         registered ALU result
//   rspN_branch_o         registered ALU branch flag
//   alu_data_a_o, alu_data_b_o, alu_func_o, alu_aluop_o   drive to the shared ALU
//   alu_result_i, alu_branch_i                            same-cycle ALU outputs
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,

   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [WIDTH-1:0] req0_a_i,
   input  logic [WIDTH-1:0] req0_b_i,
   input  logic [3:0]       req0_func_i,
   input  logic [2:0]       req0_aluop_i,

   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [WIDTH-1:0] req1_a_i,
   input  logic [WIDTH-1:0] req1_b_i,
   input  logic [3:0]       req1_func_i,
   input  logic [2:0]       req1_aluop_i,

   output logic             rsp0_valid_o,
   input  logic             rsp0_ready_i,
   output logic [WIDTH-1:0] rsp0_result_o,
   output logic             rsp0_branch_o,

   output logic             rsp1_valid_o,
   input  logic             rsp1_ready_i,
   output logic [WIDTH-1:0] rsp1_result_o,
   output logic             rsp1_branch_o,

   output logic [WIDTH-1:0] alu_data_a_o,
   output logic [WIDTH-1:0] alu_data_b_o,
   output logic [3:0]       alu_func_o,
   output logic [2:0]       alu_aluop_o,
   input  logic [WIDTH-1:0] alu_result_i,
   input  logic             alu_branch_i
);

   // ---------------------------------------------------------------------------
   // Response slot state
   // ---------------------------------------------------------------------------
   logic             rsp0_valid_q, rsp0_valid_d;
   logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
   logic             rsp0_branch_q, rsp0_branch_d;
   logic             rsp1_valid_q, rsp1_valid_d;
   logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
   logic             rsp1_branch_q, rsp1_branch_d;

   logic elig0, elig1;
   logic gnt0, gnt1;

   // A port may issue when its slot is empty or is being drained this cycle,
   // so a continuously-ready consumer sustains one issue per cycle.
   assign elig0 = req0_valid_i & (~rsp0_valid_q | rsp0_ready_i);
   assign elig1 = req1_valid_i & (~rsp1_valid_q | rsp1_ready_i);

   // ---------------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt0 = elig0;
      gnt1 = elig1 & ~elig0;
   end
`else
   // Port number of the most recent grant; reset to 1 so port 0 wins the first tie.
   logic last_grant_q, last_grant_d;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (elig0 && elig1) begin
         gnt0 = last_grant_q;
         gnt1 = ~last_grant_q;
      end else begin
         gnt0 = elig0;
         gnt1 = elig1;
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (gnt0) begin
         last_grant_d = 1'b0;
      end else if (gnt1) begin
         last_grant_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   assign req0_ready_o = gnt0;
   assign req1_ready_o = gnt1;

   // ---------------------------------------------------------------------------
   // ALU drive: winner's fields, all zero when nobody is granted
   // ---------------------------------------------------------------------------
   always_comb begin
      alu_data_a_o = '0;
      alu_data_b_o = '0;
      alu_func_o   = '0;
      alu_aluop_o  = '0;
      if (gnt0) begin
         alu_data_a_o = req0_a_i;
         alu_data_b_o = req0_b_i;
         alu_func_o   = req0_func_i;
         alu_aluop_o  = req0_aluop_i;
      end else if (gnt1) begin
         alu_data_a_o = req1_a_i;
         alu_data_b_o = req1_b_i;
         alu_func_o   = req1_func_i;
         alu_aluop_o  = req1_aluop_i;
      end
   end

   // ---------------------------------------------------------------------------
   // Slot next-state: a grant reloads (wins over a simultaneous drain); a drain
   // only clears valid so result/branch keep their last values.
   // ---------------------------------------------------------------------------
   always_comb begin
      rsp0_valid_d  = rsp0_valid_q;
      rsp0_result_d = rsp0_result_q;
      rsp0_branch_d = rsp0_branch_q;
      if (gnt0) begin
         rsp0_valid_d  = 1'b1;
         rsp0_result_d = alu_result_i;
         rsp0_branch_d = alu_branch_i;
      end else if (rsp0_ready_i) begin
         rsp0_valid_d  = 1'b0;
      end
   end

   always_comb begin
      rsp1_valid_d  = rsp1_valid_q;
      rsp1_result_d = rsp1_result_q;
      rsp1_branch_d = rsp1_branch_q;
      if (gnt1) begin
         rsp1_valid_d  = 1'b1;
         rsp1_result_d = alu_result_i;
         rsp1_branch_d = alu_branch_i;
      end else if (rsp1_ready_i) begin
         rsp1_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp0_valid_q  <= 1'b0;
         rsp0_result_q <= '0;
         rsp0_branch_q <= 1'b0;
         rsp1_valid_q  <= 1'b0;
         rsp1_result_q <= '0;
         rsp1_branch_q <= 1'b0;
      end else begin
         rsp0_valid_q  <= rsp0_valid_d;
         rsp0_result_q <= rsp0_result_d;
         rsp0_branch_q <= rsp0_branch_d;
         rsp1_valid_q  <= rsp1_valid_d;
         rsp1_result_q <= rsp1_result_d;
         rsp1_branch_q <= rsp1_branch_d;
      end
   end

   assign rsp0_valid_o  = rsp0_valid_q;
   assign rsp0_result_o = rsp0_result_q;
   assign rsp0_branch_o = rsp0_branch_q;
   assign rsp1_valid_o  = rsp1_valid_q;
   assign rsp1_result_o = rsp1_result_q;
   assign rsp1_branch_o = rsp1_branch_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Bench for alu_share_arbiter. A behavioural ALU stands in for the shared ALU.
// Expected responses are queued per port when the model predicts a grant. A
// negedge monitor compares grants, ALU drive and response slots against the
// model and pops the queues on consumption.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;
   localparam int unsigned W = 32;

   typedef struct packed {
      logic [W-1:0] res;
      logic         br;
   } rsp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]   req_valid;
   logic [1:0]   rsp_ready;
   logic [W-1:0] req_a [2];
   logic [W-1:0] req_b [2];
   logic [3:0]   req_f [2];
   logic [2:0]   req_op [2];

   logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_branch, rsp1_branch;
   logic [W-1:0] rsp0_result, rsp1_result;
   logic [W-1:0] alu_a, alu_b, alu_res;
   logic [3:0]   alu_f;
   logic [2:0]   alu_op;
   logic         alu_br;

   alu_share_arbiter #(.WIDTH(W)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req0_valid_i (req_valid[0]),
      .req0_ready_o (req0_ready),
      .req0_a_i     (req_a[0]),
      .req0_b_i     (req_b[0]),
      .req0_func_i  (req_f[0]),
      .req0_aluop_i (req_op[0]),
      .req1_valid_i (req_valid[1]),
      .req1_ready_o (req1_ready),
      .req1_a_i     (req_a[1]),
      .req1_b_i     (req_b[1]),
      .req1_func_i  (req_f[1]),
      .req1_aluop_i (req_op[1]),
      .rsp0_valid_o (rsp0_valid),
      .rsp0_ready_i (rsp_ready[0]),
      .rsp0_result_o(rsp0_result),
      .rsp0_branch_o(rsp0_branch),
      .rsp1_valid_o (rsp1_valid),
      .rsp1_ready_i (rsp_ready[1]),
      .rsp1_result_o(rsp1_result),
      .rsp1_branch_o(rsp1_branch),
      .alu_data_a_o (alu_a),
      .alu_data_b_o (alu_b),
      .alu_func_o   (alu_f),
      .alu_aluop_o  (alu_op),
      .alu_result_i (alu_res),
      .alu_branch_i (alu_br)
   );

   // Behavioural ALU: also used to compute expected responses from request fields.
   function automatic rsp_t alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] f, input logic [2:0] op);
      rsp_t r;
      r.res = '0;
      r.br  = 1'b0;
      case (op)
         3'd0: r.res = a + b;
         3'd1: r.res = a - b;
         3'd2: r.res = a & b;
         3'd3: r.res = a | b;
         3'd4: r.res = a ^ b;
         3'd5: r.res = a << b[4:0];
         3'd6: begin
            r.res = a - b;
            case (f[2:0])
               3'b000:  r.br = (a == b);
               3'b001:  r.br = (a != b);
               3'b100:  r.br = ($signed(a) < $signed(b));
               3'b101:  r.br = ($signed(a) >= $signed(b));
               3'b110:  r.br = (a < b);
               3'b111:  r.br = (a >= b);
               default: r.br = 1'b0;
            endcase
         end
         default: r.res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      endcase
      return r;
   endfunction

   assign {alu_res, alu_br} = alu_fn(alu_a, alu_b, alu_f, alu_op);

   // ---------------------------------------------------------------------------
   // Reference model state and scoreboard
   // ---------------------------------------------------------------------------
   bit   m_slot [2];
   int   m_last;
   rsp_t sb0 [$];
   rsp_t sb1 [$];
   logic [1:0] exp_gnt;
   bit   chk_on;
   int   n_chk;
   int   n_err;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_slot[0] = 1'b0;
      m_slot[1] = 1'b0;
      m_last    = 1;
      sb0.delete();
      sb1.delete();
      exp_gnt   = 2'b00;
   endtask

   // Which port should win given the current inputs and model state.
   task automatic predict();
      bit e0, e1;
      e0 = req_valid[0] && (!m_slot[0] || rsp_ready[0]);
      e1 = req_valid[1] && (!m_slot[1] || rsp_ready[1]);
      exp_gnt = 2'b00;
      if (e0 && e1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         exp_gnt = 2'b01;
`else
         exp_gnt = (m_last == 0) ? 2'b10 : 2'b01;
`endif
      end else if (e0) begin
         exp_gnt = 2'b01;
      end else if (e1) begin
         exp_gnt = 2'b10;
      end
   endtask

   // Apply the clock edge to the model: grants queue a result, idle ready drains.
   task automatic commit();
      rsp_t t;
      for (int p = 0; p < 2; p++) begin
         if (exp_gnt[p]) begin
            t = alu_fn(req_a[p], req_b[p], req_f[p], req_op[p]);
            if (p == 0) sb0.push_back(t);
            else        sb1.push_back(t);
            m_slot[p] = 1'b1;
            m_last    = p;
         end else if (rsp_ready[p]) begin
            m_slot[p] = 1'b0;
         end
      end
   endtask

   task automatic step();
      predict();
      @(posedge clk);
      commit();
      #1;
   endtask

   task automatic set_req(input int p, input logic v, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [3:0] f, input logic [2:0] op);
      req_valid[p] = v;
      req_a[p]     = a;
      req_b[p]     = b;
      req_f[p]     = f;
      req_op[p]    = op;
   endtask

   // ---------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------
   task automatic check_slot(input int p, input logic v, input logic [W-1:0] r, input logic b);
      rsp_t e;
      chk($sformatf("rsp%0d_valid", p), {63'd0, v}, {63'd0, m_slot[p]});
      if (m_slot[p]) begin
         if ((p == 0 && sb0.size() == 0) || (p == 1 && sb1.size() == 0)) begin
            n_chk++;
            n_err++;
            $display("FAIL rsp%0d_queue at %0t: got empty scoreboard expected entry", p, $time);
         end else begin
            e = (p == 0) ? sb0[0] : sb1[0];
            chk($sformatf("rsp%0d_result", p), {32'd0, r}, {32'd0, e.res});
            chk($sformatf("rsp%0d_branch", p), {63'd0, b}, {63'd0, e.br});
            if (rsp_ready[p]) begin
               if (p == 0) void'(sb0.pop_front());
               else        void'(sb1.pop_front());
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         logic [W-1:0] ea, eb;
         logic [3:0]   ef;
         logic [2:0]   eo;
         ea = '0; eb = '0; ef = '0; eo = '0;
         if (exp_gnt[0]) begin
            ea = req_a[0]; eb = req_b[0]; ef = req_f[0]; eo = req_op[0];
         end else if (exp_gnt[1]) begin
            ea = req_a[1]; eb = req_b[1]; ef = req_f[1]; eo = req_op[1];
         end
         chk("req0_ready", {63'd0, req0_ready}, {63'd0, exp_gnt[0]});
         chk("req1_ready", {63'd0, req1_ready}, {63'd0, exp_gnt[1]});
         chk("alu_data_a", {32'd0, alu_a}, {32'd0, ea});
         chk("alu_data_b", {32'd0, alu_b}, {32'd0, eb});
         chk("alu_func", {60'd0, alu_f}, {60'd0, ef});
         chk("alu_aluop", {61'd0, alu_op}, {61'd0, eo});
         check_slot(0, rsp0_valid, rsp0_result, rsp0_branch);
         check_slot(1, rsp1_valid, rsp1_result, rsp1_branch);
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      n_chk = 0;
      n_err = 0;
      chk_on = 1'b0;
      rsp_ready = 2'b00;
      set_req(0, 1'b0, '0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0, '0);
      model_reset();

      #12;
      chk("rst_rsp0_valid", {63'd0, rsp0_valid}, 64'd0);
      chk("rst_rsp1_valid", {63'd0, rsp1_valid}, 64'd0);
      chk("rst_rsp0_result", {32'd0, rsp0_result}, 64'd0);
      chk("rst_rsp1_branch", {63'd0, rsp1_branch}, 64'd0);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      chk_on = 1'b1;

      // 5 + 3 on port 0, one-cycle latency
      rsp_ready = 2'b11;
      set_req(0, 1'b1, 32'd5, 32'd3, 4'd0, 3'd0);
      step();
      chk("t1_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
      chk("t1_rsp0_result", {32'd0, rsp0_result}, 64'd8);

      // Both valid every cycle: alternating grants
      set_req(0, 1'b1, 32'd1, 32'd2, 4'd0, 3'd0);
      set_req(1, 1'b1, 32'd10, 32'd4, 4'd0, 3'd1);
      for (int i = 0; i < 8; i++) step();
      chk("t2_rsp0_result", {32'd0, rsp0_result}, 64'd3);
      chk("t2_rsp1_result", {32'd0, rsp1_result}, 64'd6);

      // Port 1 back-pressured: its slot freezes, port 0 keeps issuing
      rsp_ready = 2'b01;
      for (int i = 0; i < 6; i++) step();
      #1;
      chk("t3_req1_ready", {63'd0, req1_ready}, 64'd0);
      chk("t3_req0_ready", {63'd0, req0_ready}, 64'd1);
      chk("t3_rsp1_frozen", {32'd0, rsp1_result}, 64'd6);
      rsp_ready = 2'b11;
      step();
      step();

      // Signed branch compare on port 1
      set_req(0, 1'b0, '0, '0, '0, '0);
      set_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0100, 3'd6);
      step();
      chk("t4_branch_taken", {63'd0, rsp1_branch}, 64'd1);
      set_req(1, 1'b1, 32'd1, 32'hFFFF_FFFF, 4'b0100, 3'd6);
      step();
      chk("t4_branch_not_taken", {63'd0, rsp1_branch}, 64'd0);

      // Randomised traffic; unaccepted requests hold their fields
      for (int i = 0; i < 400; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!(req_valid[p] && !exp_gnt[p])) begin
               logic [W-1:0] a;
               a = $urandom;
               set_req(p, ($urandom_range(0, 3) != 0), a,
                       ($urandom_range(0, 3) == 0) ? a : W'($urandom),
                       4'($urandom), 3'($urandom));
            end
            rsp_ready[p] = ($urandom_range(0, 3) != 0);
         end
         step();
      end

      // Reset with both slots full; the first tie afterwards goes to port 0
      set_req(0, 1'b1, 32'd7, 32'd9, 4'd0, 3'd0);
      set_req(1, 1'b1, 32'd20, 32'd5, 4'd0, 3'd1);
      rsp_ready = 2'b00;
      for (int i = 0; i < 4; i++) step();
      chk("t5_full0", {63'd0, rsp0_valid}, 64'd1);
      chk("t5_full1", {63'd0, rsp1_valid}, 64'd1);
      #1;
      chk_on = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("t5_async_rsp0_valid", {63'd0, rsp0_valid}, 64'd0);
      chk("t5_async_rsp1_valid", {63'd0, rsp1_valid}, 64'd0);
      chk("t5_async_rsp1_result", {32'd0, rsp1_result}, 64'd0);
      model_reset();
      rsp_ready = 2'b11;
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      chk_on = 1'b1;
      #1;
      chk("t5_tie_port0", {63'd0, req0_ready}, 64'd1);
      chk("t5_tie_not_port1", {63'd0, req1_ready}, 64'd0);
      for (int i = 0; i < 4; i++) step();

      set_req(0, 1'b0, '0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0, '0);
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
